// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the
// CPU core (C) and the debug/IO port (D). One access per cycle, C priority,
// with a starvation counter that forces a D grant after STARVE_LIMIT C wins.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_req,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  output logic       c_gnt,
  output logic       c_rvalid,
  output logic [7:0] c_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic [7:0] d_rdata,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_q, streak_d;
  logic          c_rpend_q, c_rpend_d;
  logic          d_rpend_q, d_rpend_d;

  // Grant decision: C wins contention until the streak reaches the limit.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (c_req && d_req) begin
        if (streak_q >= LIMIT) d_gnt = 1'b1;
        else                   c_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Memory port mux; when idle the D address stays on the bus for switch readout.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = d_addr;
    mem_din  = 8'h00;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_addr = c_addr;
      mem_din  = c_wdata;
    end else if (d_gnt) begin
      mem_we   = d_we;
      mem_addr = d_addr;
      mem_din  = d_wdata;
    end
  end

  // Next-state for the starvation streak and read-pending flags.
  always_comb begin
    streak_d  = streak_q;
    c_rpend_d = c_gnt & ~c_we;
    d_rpend_d = d_gnt & ~d_we;
    if (d_gnt || !d_req) begin
      streak_d = '0;
    end else if (c_gnt && (streak_q < LIMIT)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q  <= '0;
      c_rpend_q <= 1'b0;
      d_rpend_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      c_rpend_q <= c_rpend_d;
      d_rpend_q <= d_rpend_d;
    end
  end

  // Read return; a reset in the return cycle suppresses the pending data.
  always_comb begin
    c_rvalid = c_rpend_q & ~rst;
    d_rvalid = d_rpend_q & ~rst;
    c_rdata  = c_rvalid ? mem_dout : 8'h00;
    d_rdata  = d_rvalid ? mem_dout : 8'h00;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter with a write-first 256x8 memory model.
module tb_dmem_arbiter;

  typedef struct packed {
    logic       rst;
    logic       c_req;
    logic       c_we;
    logic [7:0] c_addr;
    logic [7:0] c_wdata;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       e_c_gnt;
    logic       e_d_gnt;
    logic       e_mem_we;
    logic [7:0] e_mem_addr;
    logic [7:0] e_mem_din;
    logic       e_c_rvalid;
    logic [7:0] e_c_rdata;
    logic       e_d_rvalid;
    logic [7:0] e_d_rdata;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       c_req, c_we, d_req, d_we;
  logic [7:0] c_addr, c_wdata, d_addr, d_wdata;
  logic       c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [7:0] c_rdata, d_rdata;
  logic       mem_we;
  logic [7:0] mem_addr, mem_din, mem_dout;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  vec_t vecs [11];

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write-first synchronous memory model, preloaded with known contents.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hA0;
    mem[8'h01] = 8'hA1;
    mem[8'h02] = 8'hA2;
    mem[8'h07] = 8'h99;
    mem[8'h20] = 8'h33;
    mem_dout   = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) begin
        mem[mem_addr] = mem_din;
        mem_dout <= mem_din;
      end else begin
        mem_dout <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    rst     = v.rst;
    c_req   = v.c_req;
    c_we    = v.c_we;
    c_addr  = v.c_addr;
    c_wdata = v.c_wdata;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
  endtask

  task automatic chk_vec(input vec_t v, input string tag);
    chk({tag, " c_gnt"},    8'(c_gnt),    8'(v.e_c_gnt));
    chk({tag, " d_gnt"},    8'(d_gnt),    8'(v.e_d_gnt));
    chk({tag, " mem_we"},   8'(mem_we),   8'(v.e_mem_we));
    chk({tag, " mem_addr"}, mem_addr,     v.e_mem_addr);
    chk({tag, " mem_din"},  mem_din,      v.e_mem_din);
    chk({tag, " c_rvalid"}, 8'(c_rvalid), 8'(v.e_c_rvalid));
    chk({tag, " c_rdata"},  c_rdata,      v.e_c_rdata);
    chk({tag, " d_rvalid"}, 8'(d_rvalid), 8'(v.e_d_rvalid));
    chk({tag, " d_rdata"},  d_rdata,      v.e_d_rdata);
  endtask

  // Set inputs directly for the hand-written sequences.
  task automatic drive(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                       input logic [7:0] cd, input logic dr, input logic [7:0] da);
    rst     = r;
    c_req   = cr;
    c_we    = cw;
    c_addr  = ca;
    c_wdata = cd;
    d_req   = dr;
    d_we    = 1'b0;
    d_addr  = da;
    d_wdata = 8'h00;
  endtask

  initial begin
    // rst, c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata |
    // c_gnt, d_gnt, mem_we, mem_addr, mem_din, c_rvalid, c_rdata, d_rvalid, d_rdata
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h77, 1'b1, 1'b0, 8'h20, 8'h00,
                 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = vecs[0];
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b1, 1'b0, 8'h20, 8'h00,
                 1'b1, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h20, 8'h00,
                 1'b1, 1'b0, 1'b0, 8'h10, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h11,
                 1'b0, 1'b1, 1'b0, 8'h20, 8'h11, 1'b1, 8'h5A, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b0, 8'h07, 8'h55,
                 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00, 1'b1, 8'h33};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h44, 1'b0, 1'b0, 8'h07, 8'h55,
                 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00,
                 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h00,
                 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00,
                 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h07, 8'h00,
                 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA2};

    // Table-driven section: one vector per cycle, outputs sampled at negedge.
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i]);
      @(negedge clk);
      chk_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 6) chk("v6 idle mem_dout", mem_dout, 8'h99);
      @(posedge clk);
      #1;
    end

    // Starvation: continuous C reads with D waiting on 0x20.
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, (k != 6), 8'h20);
      @(negedge clk);
      chk($sformatf("starve%0d c_gnt", k), 8'(c_gnt), 8'(k != 5));
      chk($sformatf("starve%0d d_gnt", k), 8'(d_gnt), 8'(k == 5));
      chk($sformatf("starve%0d c_rvalid", k), 8'(c_rvalid), 8'((k >= 2) && (k != 6)));
      chk($sformatf("starve%0d c_rdata", k), c_rdata,
          ((k >= 2) && (k != 6)) ? 8'h5A : 8'h00);
      chk($sformatf("starve%0d d_rvalid", k), 8'(d_rvalid), 8'(k == 6));
      chk($sformatf("starve%0d d_rdata", k), d_rdata, (k == 6) ? 8'h33 : 8'h00);
      @(posedge clk);
      #1;
    end

    // Reset mid-read: C read granted, then rst with a write attempt to 0x10.
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h07);
    @(negedge clk);
    chk("rmr grant c_gnt", 8'(c_gnt), 8'h01);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b1, 8'h10, 8'hEE, 1'b1, 8'h20);
    @(negedge clk);
    chk("rmr rst c_rvalid", 8'(c_rvalid), 8'h00);
    chk("rmr rst c_rdata", c_rdata, 8'h00);
    chk("rmr rst c_gnt", 8'(c_gnt), 8'h00);
    chk("rmr rst d_gnt", 8'(d_gnt), 8'h00);
    chk("rmr rst mem_we", 8'(mem_we), 8'h00);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h07);
    @(negedge clk);
    chk("rmr after c_rvalid", 8'(c_rvalid), 8'h00);
    chk("rmr after c_gnt", 8'(c_gnt), 8'h01);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h07);
    @(negedge clk);
    chk("rmr readback c_rvalid", 8'(c_rvalid), 8'h01);
    chk("rmr readback c_rdata", c_rdata, 8'h5A);
    chk("rmr readback d_rvalid", 8'(d_rvalid), 8'h00);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
